// File: rtl/instr_decode_sb.sv
// instr_decode_sb
//   Decode stage between the IF/ID fetch register and the ID/EX units.
//   Decodes the 32-bit instruction word into ALU / memory / audio control,
//   selects operands (register or immediate), tracks pending register
//   writes in a scoreboard and stalls (inserting bubbles) on hazards.
//   Illegal encodings pass through as NOPs flagged with `illegal`.
//
//   Optional build macro: WB_FORWARD_EN
//     When defined, a source register retiring in the current cycle does
//     not stall; its operand lanes are bypassed from wb_data.
//
// Ports
//   clock, reset (sync, active low), flush
//   in_valid / in_ready / in_instr      : fetch handshake
//   reg_file                            : flattened register file, reg i at [32i+31:32i]
//   wb_valid / wb_reg / wb_en / wb_data : retiring writeback
//   out_valid / out_ready               : ID/EX handshake
//   alu_opcode, memory_access_code, audio_opcode, operand_value1/2,
//   register_writeback_enable, writeback_register_encoding,
//   audio_channel_select, illegal, id_ex_instruction : ID/EX entry
module instr_decode_sb #(
  parameter int NUM_REGS     = 8,
  parameter int NUM_AUDIO_CH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [NUM_REGS*32-1:0]   reg_file,
  input  logic                     wb_valid,
  input  logic [2:0]               wb_reg,
  input  logic [1:0]               wb_en,
  input  logic [31:0]              wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               alu_opcode,
  output logic [4:0]               memory_access_code,
  output logic [2:0]               audio_opcode,
  output logic [31:0]              operand_value1,
  output logic [31:0]              operand_value2,
  output logic [1:0]               register_writeback_enable,
  output logic [2:0]               writeback_register_encoding,
  output logic [1:0]               audio_channel_select,
  output logic                     illegal,
  output logic [31:0]              id_ex_instruction
);

  // Unimplemented register slots read as zero so selects never index
  // outside reg_file; such selects are flagged illegal anyway.
  logic [31:0] rf [8];
  for (genvar g = 0; g < 8; g++) begin : g_rf
    if (g < NUM_REGS) begin : g_impl
      assign rf[g] = reg_file[32*g +: 32];
    end else begin : g_none
      assign rf[g] = '0;
    end
  end

  logic        imm_f;
  logic [1:0]  typ;
  logic [2:0]  op;
  logic [1:0]  ch;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [15:0] imm;

  assign imm_f = in_instr[31];
  assign typ   = in_instr[30:29];
  assign op    = in_instr[28:26];
  assign ch    = in_instr[25:24];
  assign rs1   = in_instr[21:19];
  assign rs2   = in_instr[18:16];
  assign imm   = in_instr[15:0];

  logic [7:0] pending_q, pending_d;
  logic [7:0] pend_eff;
  logic [31:0] src1, src2;

  always_comb begin
    src1     = rf[rs1];
    src2     = rf[rs2];
    pend_eff = pending_q;
`ifdef WB_FORWARD_EN
    if (wb_valid) begin
      pend_eff[wb_reg] = 1'b0;
      if (wb_reg == rs1) begin
        if (wb_en[1]) src1[31:16] = wb_data[31:16];
        if (wb_en[0]) src1[15:0]  = wb_data[15:0];
      end
      if (wb_reg == rs2) begin
        if (wb_en[1]) src2[31:16] = wb_data[31:16];
        if (wb_en[0]) src2[15:0]  = wb_data[15:0];
      end
    end
`endif
  end

`ifndef WB_FORWARD_EN
  logic unused_fwd;
  assign unused_fwd = ^{wb_en, wb_data};
`endif
  logic unused_bits;
  assign unused_bits = ^in_instr[23:22];

  logic        is_arith, is_move, is_mem, is_audio;
  logic        op1_imm, op2_imm;
  logic        dec_illegal, hazard;
  logic [1:0]  wen_raw;
  logic [1:0]  dec_wen;
  logic [2:0]  dec_alu, dec_aop;
  logic [4:0]  dec_mac;
  logic [31:0] dec_op1, dec_op2;

  always_comb begin
    is_arith = (typ == 2'b01) && (op <  3'd5);
    is_move  = (typ == 2'b01) && (op >= 3'd5);
    is_mem   = (typ == 2'b10);
    is_audio = (typ == 2'b11);

    dec_illegal = (int'(rs1) >= NUM_REGS) || (int'(rs2) >= NUM_REGS) ||
                  (is_audio && (int'(ch) >= NUM_AUDIO_CH));

    op1_imm = imm_f && is_audio && ((op == 3'd4) || (op == 3'd6));
    op2_imm = imm_f && (is_arith || is_mem || (is_move && ((op == 3'd5) || (op == 3'd6))));

    if (!op1_imm)        dec_op1 = src1;
    else if (op == 3'd4) dec_op1 = {imm, 16'b0};
    else                 dec_op1 = {8'b0, imm, 8'b0};

    if (!op2_imm)                    dec_op2 = src2;
    else if (is_move && op == 3'd6)  dec_op2 = {imm, 16'b0};
    else                             dec_op2 = {16'b0, imm};

    if (is_arith)                                          wen_raw = 2'b11;
    else if ((is_move && op == 3'd5) || (is_mem && op == 3'd1)) wen_raw = 2'b01;
    else if ((is_move && op == 3'd6) || (is_mem && op == 3'd2)) wen_raw = 2'b10;
    else                                                   wen_raw = 2'b00;

    dec_alu = (is_arith || is_move) ? op : 3'd0;
    dec_mac = is_mem ? {op[2], op[1], op[1], op[0], op[0]} : 5'd0;
    dec_aop = is_audio ? op : 3'd0;
    dec_wen = wen_raw;
    if (dec_illegal) begin
      dec_alu = '0;
      dec_mac = '0;
      dec_aop = '0;
      dec_wen = '0;
    end

    // rd shares the rs1 field; checking it catches write-after-write.
    hazard = in_valid && !dec_illegal &&
             ((!op1_imm && pend_eff[rs1]) ||
              (!op2_imm && pend_eff[rs2]) ||
              ((wen_raw != 2'b00) && pend_eff[rs1]));
  end

  logic        out_valid_q, out_valid_d;
  logic [2:0]  alu_q, alu_d;
  logic [4:0]  mac_q, mac_d;
  logic [2:0]  aop_q, aop_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [1:0]  wen_q, wen_d;
  logic [2:0]  rd_q, rd_d;
  logic [1:0]  ch_q, ch_d;
  logic        ill_q, ill_d;
  logic [31:0] instr_q, instr_d;

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_d       = alu_q;
    mac_d       = mac_q;
    aop_d       = aop_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    wen_d       = wen_q;
    rd_d        = rd_q;
    ch_d        = ch_q;
    ill_d       = ill_q;
    instr_d     = instr_q;
    pending_d   = pending_q;

    if (wb_valid) pending_d[wb_reg] = 1'b0;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Stage drains this cycle: load a new entry or insert a bubble.
      out_valid_d = in_valid && !hazard;
      if (in_valid && !hazard) begin
        alu_d   = dec_alu;
        mac_d   = dec_mac;
        aop_d   = dec_aop;
        op1_d   = dec_op1;
        op2_d   = dec_op2;
        wen_d   = dec_wen;
        rd_d    = rs1;
        ch_d    = ch;
        ill_d   = dec_illegal;
        instr_d = in_instr;
        if (dec_wen != 2'b00) pending_d[rs1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      mac_q       <= '0;
      aop_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      wen_q       <= '0;
      rd_q        <= '0;
      ch_q        <= '0;
      ill_q       <= 1'b0;
      instr_q     <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      mac_q       <= mac_d;
      aop_q       <= aop_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      wen_q       <= wen_d;
      rd_q        <= rd_d;
      ch_q        <= ch_d;
      ill_q       <= ill_d;
      instr_q     <= instr_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid                   = out_valid_q;
  assign alu_opcode                  = alu_q;
  assign memory_access_code          = mac_q;
  assign audio_opcode                = aop_q;
  assign operand_value1              = op1_q;
  assign operand_value2              = op2_q;
  assign register_writeback_enable   = wen_q;
  assign writeback_register_encoding = rd_q;
  assign audio_channel_select        = ch_q;
  assign illegal                     = ill_q;
  assign id_ex_instruction           = instr_q;

endmodule

// File: doc/instr_decode_sb.md
Name: instr_decode_sb

Overview:
- Parametrised successor decode stage for the RISC CPU, sitting between the fetch register (IF/ID) and execute/memory/audio units (ID/EX).
- Adds valid/ready handshakes on both sides, a per-register pending-write scoreboard with stall/bubble insertion, illegal-encoding detection, flush, and configurable register and audio channel counts.
- Instruction format: [31] imm flag, [30:29] type, [28:26] op, [25:24] channel, [21:19] rs1/rd, [18:16] rs2, [15:0] imm.

Parameters:
- NUM_REGS, 8, architectural registers implemented (1..8); selects >= NUM_REGS are illegal.
- NUM_AUDIO_CH, 4, audio channels implemented (1..4); channel field >= NUM_AUDIO_CH on audio ops is illegal.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard the output stage and the current input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  decode accepts it this cycle (combinational).
- in_instr  in  32  instruction word.
- reg_file  in  NUM_REGS*32  flattened register file, reg i at [32i+31:32i].
- wb_valid  in  1  a writeback retires this cycle.
- wb_reg  in  3  retiring destination.
- wb_en  in  2  retiring lane enables ([1] upper, [0] lower).
- wb_data  in  32  retiring data.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  execute accepts the entry.
- alu_opcode  out  3  ALU operation.
- memory_access_code  out  5  {op[2],op[1],op[1],op[0],op[0]} for memory ops, else 0.
- audio_opcode  out  3  audio operation.
- operand_value1  out  32  first operand.
- operand_value2  out  32  second operand.
- register_writeback_enable  out  2  11 full, 01 lower, 10 upper, 00 none.
- writeback_register_encoding  out  3  rd.
- audio_channel_select  out  2  channel field.
- illegal  out  1  entry was an illegal encoding, converted to a NOP.
- id_ex_instruction  out  32  raw instruction, for VGA debug.

Behaviour:
- Reset (reset==0 at a clock edge): every output register is 0, out_valid=0, scoreboard cleared. This overrides flush and all other inputs.
- Classes:
  - type 00: nop.
  - type 01, op in {101,110,111}: move.
  - type 01, other ops: arithmetic.
  - type 10: memory.
  - type 11: audio.
- Opcode fields: same mapping for all classes; fields not belonging to the class are 0.
- Operands (imm flag set):
  - arithmetic, memory, or move 101: op2={16'b0,imm}.
  - move 110: op2={imm,16'b0}.
  - audio op 100: op1={imm,16'b0}.
  - audio op 110: op1={8'b0,imm,8'b0}.
  - any other class with the imm flag set: both operands come from registers.
  - The operand not named in each case above comes from its register.
- Writeback enable:
  - arithmetic: 11.
  - move 101 or memory 001: 01.
  - move 110 or memory 010: 10.
  - otherwise: 00.
  - A source register is "used" only where an operand is taken from it.
- Hazard: asserted when a used source, or the rd of an instruction whose wb_en != 0, has its pending bit set.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Latency: 1 cycle. An accepted instruction appears on the outputs, with out_valid=1, on the next edge. Outputs hold stable while out_valid && !out_ready.
- Bubble: if a hazard exists and downstream accepts (or out_valid==0), out_valid=0 on the next edge.
- Scoreboard:
  - Issue sets pending[rd] when register_writeback_enable != 0.
  - wb_valid clears pending[wb_reg].
  - Same reg set and cleared in the same cycle: set wins.
  - A clear in cycle N removes a hazard from cycle N+1 onward; reg_file is updated by then.
- Illegal: rd/rs1 or rs2 >= NUM_REGS, or audio channel >= NUM_AUDIO_CH.
  - Illegal entries pass downstream with illegal=1, all opcodes 0, wb_en 00, and no scoreboard set.
  - Illegal entries do not stall.
- Flush: next edge out_valid=0. The input is not accepted. The scoreboard is preserved, because older writes still retire.
- Flush and reset: reset wins.

Optional Feature:
- Macro WB_FORWARD_EN.
- Defined:
  - A pending source matching wb_reg while wb_valid is high does not stall in that cycle.
  - Operands are bypassed per lane: lanes with wb_en set take wb_data, the other lanes come from reg_file.
  - The scoreboard clear still applies.
- Undefined: no bypass path; the hazard persists until the cycle after the clear.

Test Plan:
- Reset low with in_valid=1 -> all outputs 0, out_valid=0; release reset, then in_instr=0x2408_0000 (ADD-class op 001, rd=1, rs2=0), reg1=5, reg0=7 -> next cycle alu_opcode=001, operands 5/7, wb_en=11, rd=1.
- Issue arithmetic to rd=2, then an instruction reading rs1=2 with no wb -> in_ready=0, bubble (out_valid=0) each cycle. wb_valid with wb_reg=2 -> issue one cycle later (same cycle if WB_FORWARD_EN, with op1=wb_data).
- out_ready=0 for 3 cycles with out_valid=1 -> all outputs constant, in_ready=0. Raise out_ready -> next instruction appears the following cycle.
- NUM_AUDIO_CH=2, audio op 100, channel 3, imm 0x1234 -> illegal=1, audio_opcode=0, wb_en=00, scoreboard unchanged.
- Move upper immediate 110 with imm=0xBEEF -> op2=0xBEEF0000, wb_en=10. Same instruction with 101 -> op2=0x0000BEEF, wb_en=01.
- Flush while out_valid=1 and in_valid=1 -> out_valid=0 next edge, input not consumed, earlier pending bit for rd stays set until wb_valid.
